// File: rtl/pipe_trace_buf.sv
// +--------------------------------------------------------------------------+
// | pipe_trace_buf : triggered circular trace buffer for CPU pipeline taps    |
// | Optional: TRACE_STALL_FILTER_EN drops repeats of the last written word    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_trace_buf #(
  parameter int DW    = 32,
  parameter int CH    = 4,
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int CW    = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [CH*DW-1:0] Ch_Data,
  input  logic             Sample_En,
  input  logic             Arm,
  input  logic [DW-1:0]    Trig_PC,
  input  logic [DW-1:0]    Trig_Mask,
  input  logic [AW-1:0]    Post_Cnt,
  input  logic [AW-1:0]    Rd_Idx,
  input  logic [CW-1:0]    Rd_Ch,
  output logic [DW-1:0]    Rd_Data,
  output logic             Busy,
  output logic             Done,
  output logic [AW:0]      Valid_Cnt,
  output logic [AW-1:0]    Trig_Pos
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t state, state_nxt;

  logic [CH*DW-1:0] mem [DEPTH];

  logic [AW-1:0] wp, wp_nxt;
  logic [AW:0]   valid_cnt, valid_nxt, valid_inc, tp_full;
  logic [AW-1:0] post_ctr, post_ctr_nxt;
  logic [AW-1:0] post_lat, post_lat_nxt;
  logic [AW-1:0] trig_pos, trig_pos_nxt;
  logic          capturing, trig_hit, filtered, do_write;

  logic [AW-1:0]    rd_addr;
  logic             rd_ok;
  logic [CH*DW-1:0] rd_word;
  logic [DW-1:0]    rd_sel, rd_data;

  assign capturing = (state == S_ARMED) || (state == S_POST);
  assign trig_hit  = ((Ch_Data[DW-1:0] ^ Trig_PC) & Trig_Mask) == '0;
  assign do_write  = Sample_En && capturing && !Arm && !Rst && !filtered;

`ifdef TRACE_STALL_FILTER_EN
  // The first sample after Arm must always land, even if it matches stale history.
  logic [CH*DW-1:0] last_word;
  logic             first_smp;

  assign filtered = !first_smp && (Ch_Data == last_word);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      first_smp <= 1'b1;
      last_word <= '0;
    end else if (Arm) begin
      first_smp <= 1'b1;
    end else if (do_write) begin
      first_smp <= 1'b0;
      last_word <= Ch_Data;
    end
  end
`else
  assign filtered = 1'b0;
`endif

  assign valid_inc = (valid_cnt == FULL) ? FULL : valid_cnt + (AW+1)'(1);
  assign tp_full   = valid_inc - (AW+1)'(1) - {1'b0, post_lat};

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    wp_nxt       = wp;
    valid_nxt    = valid_cnt;
    post_ctr_nxt = post_ctr;
    post_lat_nxt = post_lat;
    trig_pos_nxt = trig_pos;
    if (Arm) begin
      state_nxt    = S_ARMED;
      wp_nxt       = '0;
      valid_nxt    = '0;
      post_ctr_nxt = Post_Cnt;
      post_lat_nxt = Post_Cnt;
    end else if (do_write) begin
      wp_nxt    = wp + AW'(1);
      valid_nxt = valid_inc;
      if (state == S_ARMED && trig_hit) begin
        if (post_lat == '0) begin
          state_nxt    = S_DONE;
          trig_pos_nxt = tp_full[AW-1:0];
        end else begin
          state_nxt = S_POST;
        end
      end else if (state == S_POST) begin
        post_ctr_nxt = post_ctr - AW'(1);
        if (post_ctr == AW'(1)) begin
          state_nxt    = S_DONE;
          trig_pos_nxt = tp_full[AW-1:0];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wp        <= '0;
      valid_cnt <= '0;
      post_ctr  <= '0;
      post_lat  <= '0;
      trig_pos  <= '0;
    end else begin
      wp        <= wp_nxt;
      valid_cnt <= valid_nxt;
      post_ctr  <= post_ctr_nxt;
      post_lat  <= post_lat_nxt;
      trig_pos  <= trig_pos_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_write) mem[wp] <= Ch_Data;
  end

  // Once the ring has wrapped, the write pointer marks the oldest entry.
  assign rd_addr = ((valid_cnt == FULL) ? wp : '0) + Rd_Idx;
  assign rd_ok   = {1'b0, Rd_Idx} < valid_cnt;
  assign rd_word = mem[rd_addr];

  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < CH; c++) begin
      if (Rd_Ch == CW'(c)) rd_sel = rd_word[c*DW +: DW];
    end
  end

  // Out-of-range indices hold the previous value so unwritten RAM never escapes.
  always_ff @(posedge Clk) begin
    if (Rst)        rd_data <= '0;
    else if (rd_ok) rd_data <= rd_sel;
  end

  assign Rd_Data   = rd_data;
  assign Busy      = capturing;
  assign Done      = (state == S_DONE);
  assign Valid_Cnt = valid_cnt;
  assign Trig_Pos  = trig_pos;

endmodule

`default_nettype wire

// File: tb/tb_pipe_trace_buf.sv
// Self-checking bench for pipe_trace_buf: status vector table plus read scoreboard.
`default_nettype none

module tb_pipe_trace_buf;
  localparam int DW = 32, CH = 3, DEPTH = 8, AW = 3, CW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH*DW-1:0] ch_data;
  logic             sample_en, arm;
  logic [DW-1:0]    trig_pc, trig_mask;
  logic [AW-1:0]    post_cnt, rd_idx;
  logic [CW-1:0]    rd_ch;
  logic [DW-1:0]    rd_data;
  logic             busy, done;
  logic [AW:0]      valid_cnt;
  logic [AW-1:0]    trig_pos;

  pipe_trace_buf #(.DW(DW), .CH(CH), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .Clk(clk), .Rst(rst), .Ch_Data(ch_data), .Sample_En(sample_en), .Arm(arm),
    .Trig_PC(trig_pc), .Trig_Mask(trig_mask), .Post_Cnt(post_cnt),
    .Rd_Idx(rd_idx), .Rd_Ch(rd_ch), .Rd_Data(rd_data), .Busy(busy), .Done(done),
    .Valid_Cnt(valid_cnt), .Trig_Pos(trig_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          arm;
    logic [AW-1:0] post;
    logic          en;
    logic [DW-1:0] pc;
    logic          e_busy;
    logic          e_done;
    logic [AW:0]   e_valid;
  } vec_t;

  vec_t          vt [12];
  logic [DW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic logic [CH*DW-1:0] word(input logic [DW-1:0] pc);
    return {pc + 32'd1, ~pc, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic status(input string name, input logic b, input logic d, input logic [AW:0] v);
    chk({name, ".busy"}, 64'(busy), 64'(b));
    chk({name, ".done"}, 64'(done), 64'(d));
    chk({name, ".valid"}, 64'(valid_cnt), 64'(v));
  endtask

  task automatic drive(input logic en, input logic [DW-1:0] pc);
    sample_en = en;
    ch_data   = word(pc);
  endtask

  task automatic rd_check(input string name, input logic [AW-1:0] idx, input logic [CW-1:0] ch,
                          input logic [DW-1:0] exp);
    sample_en = 1'b0;
    rd_idx    = idx;
    rd_ch     = ch;
    exp_q.push_back(exp);
    tick();
    chk(name, 64'(rd_data), 64'(exp_q.pop_front()));
  endtask

  task automatic setv(input int i, input logic a, input logic [AW-1:0] p, input logic en,
                      input logic [DW-1:0] pc, input logic b, input logic d, input logic [AW:0] v);
    vt[i] = '{arm: a, post: p, en: en, pc: pc, e_busy: b, e_done: d, e_valid: v};
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      arm      = vt[i].arm;
      post_cnt = vt[i].post;
      drive(vt[i].en, vt[i].pc);
      tick();
      status($sformatf("row%0d", i), vt[i].e_busy, vt[i].e_done, vt[i].e_valid);
    end
    arm       = 1'b0;
    sample_en = 1'b0;
  endtask

  task automatic arm_pulse(input logic [AW-1:0] p);
    arm = 1'b1; post_cnt = p; sample_en = 1'b0;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Post_Cnt on non-Arm rows is deliberately wrong; only the Arm-cycle value may count.
    setv(0,  1, 3'd3, 1, 32'h99, 1, 0, 4'd0);
    setv(1,  0, 3'd7, 1, 32'h00, 1, 0, 4'd1);
    setv(2,  0, 3'd7, 1, 32'h04, 1, 0, 4'd2);
    setv(3,  0, 3'd7, 1, 32'h08, 1, 0, 4'd3);
    setv(4,  0, 3'd7, 1, 32'h0C, 0, 1, 4'd4);
    setv(5,  0, 3'd7, 1, 32'h10, 0, 1, 4'd4);
    setv(6,  1, 3'd2, 0, 32'h00, 1, 0, 4'd0);
    setv(7,  0, 3'd0, 1, 32'h00, 1, 0, 4'd1);
    setv(8,  0, 3'd0, 0, 32'h04, 1, 0, 4'd1);
    setv(9,  0, 3'd0, 1, 32'h08, 1, 0, 4'd2);
    setv(10, 0, 3'd0, 0, 32'h0C, 1, 0, 4'd2);
    setv(11, 0, 3'd0, 1, 32'h10, 0, 1, 4'd3);

    rst = 1'b1; arm = 1'b0; sample_en = 1'b0; ch_data = '0;
    trig_pc = '0; trig_mask = '0; post_cnt = '0; rd_idx = '0; rd_ch = '0;
    tick(); tick();
    status("reset", 0, 0, 4'd0);
    chk("reset.trig_pos", 64'(trig_pos), 64'd0);
    chk("reset.rd_data", 64'(rd_data), 64'd0);
    rst = 1'b0;

    // Mask 0: first sample triggers, three post samples follow.
    apply_rows(0, 5);
    chk("t1.trig_pos", 64'(trig_pos), 64'd0);
    for (int i = 0; i < 4; i++) begin
      rd_check($sformatf("t1.rd%0d", i), AW'(i), 2'd0, DW'(4 * i));
      rd_check($sformatf("t1.rd%0d.ch1", i), AW'(i), 2'd1, ~DW'(4 * i));
    end

    // Sample_En toggling in POST: only enabled cycles are written.
    apply_rows(6, 11);
    chk("t3.trig_pos", 64'(trig_pos), 64'd0);
    rd_check("t3.rd0", 3'd0, 2'd0, 32'h00);
    rd_check("t3.rd1", 3'd1, 2'd0, 32'h08);
    rd_check("t3.rd2", 3'd2, 2'd0, 32'h10);

    // Exact-match trigger with wrap-around history.
    trig_pc = 32'h40; trig_mask = 32'hFFFF_FFFF;
    arm_pulse(3'd2);
    for (int k = 0; k < 40; k++) begin
      if (done) break;
      drive(1'b1, DW'(4 * k));
      if (k == 10) begin
        rd_idx = 3'd0; rd_ch = 2'd0;
        exp_q.push_back(32'h08);
      end
      tick();
      if (k == 10) chk("t2.read_first", 64'(rd_data), 64'(exp_q.pop_front()));
    end
    sample_en = 1'b0;
    status("t2.end", 0, 1, 4'd8);
    chk("t2.trig_pos", 64'(trig_pos), 64'd5);
    for (int i = 0; i < 8; i++)
      rd_check($sformatf("t2.rd%0d", i), AW'(i), 2'd0, 32'h2C + DW'(4 * i));
    rd_check("t2.rd5.ch2", 3'd5, 2'd2, 32'h41);
    rd_check("t2.rd2.ch3", 3'd2, 2'd3, 32'h0);

    // Arm from DONE restarts.
    arm_pulse(3'd1);
    status("rearm", 1, 0, 4'd0);

    // Reset two cycles into POST, with Arm asserted alongside it.
    trig_mask = '0;
    arm_pulse(3'd5);
    drive(1'b1, 32'h0); tick();
    drive(1'b1, 32'h4); tick();
    drive(1'b1, 32'h8); tick();
    status("post_mid", 1, 0, 4'd3);
    rst = 1'b1; arm = 1'b1; drive(1'b1, 32'hC);
    tick();
    rst = 1'b0; arm = 1'b0; sample_en = 1'b0;
    status("rst_abort", 0, 0, 4'd0);
    chk("rst_abort.trig_pos", 64'(trig_pos), 64'd0);
    chk("rst_abort.rd_data", 64'(rd_data), 64'd0);
    arm = 1'b1; post_cnt = 3'd1; drive(1'b1, 32'h200);
    tick();
    arm = 1'b0;
    status("restart.arm", 1, 0, 4'd0);
    drive(1'b1, 32'h300); tick();
    status("restart.s0", 1, 0, 4'd1);
    drive(1'b1, 32'h304); tick();
    status("restart.s1", 0, 1, 4'd2);
    rd_check("restart.rd0", 3'd0, 2'd0, 32'h300);
    rd_check("restart.rd1", 3'd1, 2'd0, 32'h304);

    // Stall sequence 0,4,4,4,8.
    arm_pulse(3'd2);
    drive(1'b1, 32'h0); tick();
    drive(1'b1, 32'h4); tick();
    drive(1'b1, 32'h4); tick();
`ifdef TRACE_STALL_FILTER_EN
    status("stall.s2", 1, 0, 4'd2);
`else
    status("stall.s2", 0, 1, 4'd3);
`endif
    drive(1'b1, 32'h4); tick();
    drive(1'b1, 32'h8); tick();
    status("stall.end", 0, 1, 4'd3);
    rd_check("stall.rd0", 3'd0, 2'd0, 32'h0);
    rd_check("stall.rd1", 3'd1, 2'd0, 32'h4);
`ifdef TRACE_STALL_FILTER_EN
    rd_check("stall.rd2", 3'd2, 2'd0, 32'h8);
`else
    rd_check("stall.rd2", 3'd2, 2'd0, 32'h4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_trace_buf.md
Name: pipe_trace_buf

Overview:
- Synthesizable on-board trace buffer for the pipelined CPU's debug taps (I_PC, I_Inst, E_ALUout, M_ALUout, W_RegDin, ...).
- Generalises the fixed-width, free-running simulation observation into a parametrised capture block with:
  - CH channels of DW bits;
  - a DEPTH-entry circular history;
  - a masked PC trigger with pre/post-trigger window;
  - random-access readout after capture.
- Sits beside the CPU core in the top level.
- Feeds a debug readout path such as a UART dumper or ILA-style reader.

Parameters:
DW, 32, width of each traced channel
CH, 4, number of channels; channel 0 is the trigger (PC) channel
DEPTH, 64, number of samples stored; power of two, >= 4
AW, 6, log2(DEPTH)
CW, 2, channel-select width, ceil(log2(CH)), minimum 1

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst  in  1  synchronous, active-high reset
Ch_Data  in  CH*DW  packed channel samples, channel 0 in bits [DW-1:0]
Sample_En  in  1  capture qualifier (pipeline advanced this cycle)
Arm  in  1  single-cycle pulse: clear buffer, start capture
Trig_PC  in  DW  trigger compare value for channel 0
Trig_Mask  in  DW  compare mask, 1 = bit participates
Post_Cnt  in  AW  samples to store after the trigger sample, 0..DEPTH-1; latched on Arm
Rd_Idx  in  AW  read index, 0 = oldest stored sample
Rd_Ch  in  CW  read channel select
Rd_Data  out  DW  registered read data
Busy  out  1  high in ARMED or POST
Done  out  1  high in DONE
Valid_Cnt  out  AW+1  samples stored, saturates at DEPTH
Trig_Pos  out  AW  index (oldest-relative) of the trigger sample, valid when Done

Behaviour:
Reset:
- Rst is sampled on Clk.
- Forces state IDLE; wp=0; Valid_Cnt=0; Trig_Pos=0; Rd_Data=0; Busy=0; Done=0.
- Buffer RAM contents are not cleared.
- Rst mid-capture aborts with no further writes.
- Rst has priority over Arm.

FSM: IDLE -> ARMED -> POST -> DONE.
- IDLE: no writes.
- Arm in any state (not Rst):
  - next cycle ARMED;
  - wp=0, Valid_Cnt=0, post counter := Post_Cnt;
  - the Arm-cycle sample is never written.
- ARMED, Sample_En=1:
  - write Ch_Data at wp; wp++ mod DEPTH; Valid_Cnt++ saturating at DEPTH;
  - when full, overwrite the oldest entry (wrap).
  - If ((Ch_Data[DW-1:0] ^ Trig_PC) & Trig_Mask)==0, the written sample is the trigger:
    - Post_Cnt==0: go to DONE;
    - otherwise go to POST.
  - Trig_Mask=0 triggers on the first enabled sample.
- POST, Sample_En=1:
  - write as above; decrement the post counter;
  - go to DONE when it reaches 0 after this write.
  - No further triggers are evaluated.
- Sample_En=0: no write, no count, no trigger check, in any state.
- DONE: holds; no writes; leaves only on Arm or Rst.
- Post_Cnt is sampled only on Arm; changes during capture are ignored.

Trigger position:
- Trig_Pos = Valid_Cnt - 1 - latched Post_Cnt.
- Registered on entry to DONE.
- If pre-trigger history was overwritten, Trig_Pos = DEPTH-1-Post_Cnt.

Readout:
- Physical address = (oldest + Rd_Idx) mod DEPTH.
- oldest = wp if Valid_Cnt==DEPTH, else 0.
- Rd_Data = channel Rd_Ch of that entry, one-cycle latency, in any state.
- Rd_Idx >= Valid_Cnt returns a stale value; defined only as "no X after reset".
- Rd_Ch >= CH returns 0.
- Simultaneous write and read of the same address returns the old data (read-first).

Optional Feature:
TRACE_STALL_FILTER_EN
- Defined: in ARMED/POST, a Sample_En=1 sample whose full CH*DW word equals the last written word is discarded, giving stall/bubble compression:
  - no write, no count, no trigger check.
  - The first sample after Arm is always written.
- Undefined: every Sample_En=1 sample is written; no comparison register exists.

Test Plan:
- DEPTH=8, Arm, Trig_Mask=0, Post_Cnt=3, PC=0,4,8,... each cycle -> Done after 4 samples; Valid_Cnt=4; Trig_Pos=0; Rd_Idx 0..3 ch0 = 0,4,8,12.
- DEPTH=8, Trig_PC=0x40, mask 0xFFFFFFFF, Post_Cnt=2, PC steps by 4 from 0 -> Valid_Cnt=8; Trig_Pos=5; Rd_Idx 0..7 ch0 = 0x2C..0x48; Rd_Idx 5 = 0x40.
- Sample_En toggling 1,0,1,0 in POST with Post_Cnt=2 -> only enabled cycles are written; Done only after the 2nd enabled post sample.
- Rst asserted 2 cycles into POST -> next cycle Busy=0, Done=0, Valid_Cnt=0; Arm then restarts cleanly.
- Arm asserted while DONE -> Done drops next cycle; Busy=1; Valid_Cnt=0.
- With TRACE_STALL_FILTER_EN, PC sequence 0,4,4,4,8, Trig_Mask=0, Post_Cnt=2 -> entries 0,4,8; Valid_Cnt=3; without the macro, Done after 0,4,4 with Valid_Cnt=3.
